mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port 4K x 16 synchronous program/data memory between the P1
//  instruction-fetch port and the P4 load/store port of the 5-stage core.
//  Grants at most one access per cycle and routes read data back to the owner.
//  Produces the fetch-stall condition the pipeline uses to freeze P1/P2.
// PARAMETERS
//  ADDR_W      12  memory word-address width
//  DATA_W      16  memory data width
//  STARVE_MAX  4   consecutive fetch denials before fetch wins one slot; 0 = strict data priority
// PORTS
//  clock      in   1       system clock, all state on rising edge
//  reset      in   1       asynchronous, active-high
//  if_req     in   1       fetch read request, held with if_addr until if_gnt
//  if_addr    in   ADDR_W  fetch address (PC)
//  if_gnt     out  1       fetch address accepted this cycle
//  if_rvalid  out  1       if_rdata valid (cycle after if_gnt)
//  if_rdata   out  DATA_W  fetched instruction word
//  d_req      in   1       data request, held with d_we/d_addr/d_wdata until d_gnt
//  d_we       in   1       1 = store (ST), 0 = load (LD)
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_gnt      out  1       data access accepted this cycle
//  d_rvalid   out  1       d_rdata valid (cycle after a load grant; never for stores)
//  d_rdata    out  DATA_W  load data
//  stall      out  1       if_req & ~if_gnt; pipeline holds P1 PC and P2 IR
//  m_addr     out  ADDR_W  memory address
//  m_data     out  DATA_W  memory write data
//  m_rw       out  1       1 = write, 0 = read
//  m_q        in   DATA_W  memory read data, valid one cycle after address is sampled
// BEHAVIOUR
//  - Reset: if_gnt/d_gnt/if_rvalid/d_rvalid = 0, rdata = 0, m_rw = 0, m_addr = 0,
//    m_data = 0, owner = NONE, starve_cnt = 0. Reset mid-read drops the read: no rvalid afterward.
//  - Grant is combinational from the current requests and registered starve_cnt.
//    d_req only -> data. if_req only -> fetch. Both -> data, unless
//    STARVE_MAX != 0 and starve_cnt == STARVE_MAX -> fetch.
//  - Memory bus is combinational from the granted requester: m_addr/m_rw/m_data.
//    m_data = d_wdata on store, else 0. No grant: m_addr = 0, m_rw = 0, m_data = 0.
//  - owner register = {NONE, IF_RD, D_RD, D_WR}, loaded every cycle with this cycle's grant.
//    Next cycle: IF_RD -> if_rvalid = 1, if_rdata = m_q. D_RD -> d_rvalid = 1, d_rdata = m_q.
//    D_WR/NONE -> both rvalid = 0. Non-owned rdata outputs hold 0.
//  - Latency: grant in cycle t, data in cycle t+1. Throughput 1 access/cycle with back-to-back grants.
//  - starve_cnt: +1 when if_req high and fetch denied, saturating at STARVE_MAX.
//    Cleared when fetch granted or if_req low.
//  - Ordering: accesses hit memory in grant order. A load granted the cycle after a
//    store to the same address returns the new data.
//  - Grant while the request is dropped by the requester: not possible (no grant without req).
//    A request must not change before its grant; changing it is a protocol violation, unchecked.
// STRUCTURE
//  - Shared package simple_ps_pkg: OWN_NONE/OWN_IF_RD/OWN_D_RD/OWN_D_WR (2-bit),
//    MEM_READ = 1'b0, MEM_WRITE = 1'b1.
//  - One sub-module: arb_starve_counter (saturating counter, inc/clr/at_max).
//  - Grant mux and owner register live in this module.
// TESTING
//  - Reset released, if_req=1, if_addr 0..7 each cycle, d_req=0 -> if_gnt every cycle,
//    if_rvalid from 2nd cycle, if_rdata = mem[0..7].
//  - if_req=1 @0x010, d_req=1 d_we=0 @0x800 same cycle -> d_gnt=1, if_gnt=0, stall=1.
//    Next cycle: d_rvalid, d_rdata = mem[0x800], if_gnt=1.
//  - Store 0xBEEF @0x123, then load @0x123 next cycle -> m_rw 1 then 0,
//    d_rvalid=1 with 0xBEEF, no d_rvalid for the store.
//  - STARVE_MAX=4, d_req held 8 cycles, if_req held -> grants D,D,D,D,IF,D,D,D.
//    With STARVE_MAX=0 -> data all 8 cycles.
//  - Assert reset the cycle after a load grant -> d_rvalid stays 0, all outputs 0.
//    After release, a fresh fetch completes normally.

Source files
------------

// File: rtl/simple_ps_pkg.sv
// Shared types for the simple pipelined core: memory-slot owner encoding
// and memory bus direction constants.
package simple_ps_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_IF_RD = 2'd1,
        OWN_D_RD  = 2'd2,
        OWN_D_WR  = 2'd3
    } owner_e;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive fetch denials; at_max tells the arbiter
// that the fetch port is owed the next slot.
module arb_starve_counter #(
    parameter int unsigned MAX = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // MAX of zero means the fetch port never forces its way in.
    assign at_max = (MAX != 0) && (cnt_q == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port program/data memory between instruction fetch
// and load/store, returning read data to whichever port owned the slot.
module mem_port_arbiter
    import simple_ps_pkg::*;
#(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data,
    output logic              m_rw,
    input  logic [DATA_W-1:0] m_q
);

    // Handshake: a requester holds req and its payload until gnt; gnt is the
    // accept, and read data comes back exactly one cycle later with rvalid.
    owner_e owner_q;
    owner_e owner_d;
    logic   starve_at_max;

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!reset) begin
            if (d_req && !(if_req && starve_at_max)) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        m_addr  = '0;
        m_data  = '0;
        m_rw    = MEM_READ;
        owner_d = OWN_NONE;
        if (d_gnt) begin
            m_addr = d_addr;
            if (d_we) begin
                m_rw    = MEM_WRITE;
                m_data  = d_wdata;
                owner_d = OWN_D_WR;
            end else begin
                owner_d = OWN_D_RD;
            end
        end else if (if_gnt) begin
            m_addr  = if_addr;
            owner_d = OWN_IF_RD;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign if_rvalid = (owner_q == OWN_IF_RD);
    assign d_rvalid  = (owner_q == OWN_D_RD);
    assign if_rdata  = if_rvalid ? m_q : '0;
    assign d_rdata   = d_rvalid ? m_q : '0;
    assign stall     = if_req & ~if_gnt;

    arb_starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clock  (clock),
        .reset  (reset),
        .inc    (if_req & ~if_gnt),
        .clr    (if_gnt | ~if_req),
        .at_max (starve_at_max)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences and a
// randomized run, all checked against a cycle-level reference model.
module tb_mem_port_arbiter;

    localparam int AW   = 12;
    localparam int DW   = 16;
    localparam int SMAX = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, stall, m_rw;
    logic [DW-1:0] if_rdata, d_rdata, m_data, m_q;
    logic [AW-1:0] m_addr;

    logic          s_if_gnt, s_if_rvalid, s_d_gnt, s_d_rvalid, s_stall, s_m_rw;
    logic [DW-1:0] s_if_rdata, s_d_rdata, s_m_data;
    logic [AW-1:0] s_m_addr;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .stall(stall), .m_addr(m_addr), .m_data(m_data), .m_rw(m_rw), .m_q(m_q)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(0)) dut_strict (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(s_if_gnt),
        .if_rvalid(s_if_rvalid), .if_rdata(s_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(s_d_gnt), .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata),
        .stall(s_stall), .m_addr(s_m_addr), .m_data(s_m_data), .m_rw(s_m_rw),
        .m_q('0)
    );

    // Synchronous 4K x 16 memory: read-before-write, data one cycle later.
    logic [DW-1:0] mem [0:4095];
    always @(posedge clock) begin
        if (m_rw) mem[m_addr] <= m_data;
        m_q <= mem[m_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [0:4095];
    logic [DW-1:0] exp_q[$];
    int            starve;
    bit            pend_if, pend_d, last_fw, last_dw;

    // Values observed at the last step's sampling point
    logic          obs_if_gnt, obs_d_gnt, obs_stall, obs_m_rw, obs_d_rvalid;
    logic          obs_s_if_gnt, obs_s_d_gnt;
    logic [DW-1:0] obs_d_rdata;

    typedef struct {
        logic          ir;
        logic [AW-1:0] ia;
        logic          dr;
        logic          dwe;
        logic [AW-1:0] da;
        logic [DW-1:0] dw;
        logic          e_ig;
        logic          e_dg;
        logic          e_stall;
        logic          e_rw;
        logic          sc;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        starve  = 0;
        pend_if = 1'b0;
        pend_d  = 1'b0;
        exp_q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_if_gnt"}, 32'(if_gnt), 0);
        chk({tag, "_d_gnt"}, 32'(d_gnt), 0);
        chk({tag, "_if_rvalid"}, 32'(if_rvalid), 0);
        chk({tag, "_d_rvalid"}, 32'(d_rvalid), 0);
        chk({tag, "_if_rdata"}, 32'(if_rdata), 0);
        chk({tag, "_d_rdata"}, 32'(d_rdata), 0);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_m_addr"}, 32'(m_addr), 0);
        chk({tag, "_m_rw"}, 32'(m_rw), 0);
        chk({tag, "_m_data"}, 32'(m_data), 0);
    endtask

    // One clock cycle: apply requests, check every output against the model
    // on the falling edge, then advance the model to the next cycle.
    task automatic step(input logic ir, input logic [AW-1:0] ia, input logic dr,
                        input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dw);
        bit            fw, dwn;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_ir, e_dr;
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dw;
        fw      = ir && (!dr || (SMAX != 0 && starve == SMAX));
        dwn     = dr && !fw;
        e_addr  = dwn ? da : (fw ? ia : '0);
        @(negedge clock);
        obs_if_gnt   = if_gnt;
        obs_d_gnt    = d_gnt;
        obs_stall    = stall;
        obs_m_rw     = m_rw;
        obs_d_rvalid = d_rvalid;
        obs_d_rdata  = d_rdata;
        obs_s_if_gnt = s_if_gnt;
        obs_s_d_gnt  = s_d_gnt;
        chk("if_gnt", 32'(if_gnt), 32'(fw));
        chk("d_gnt", 32'(d_gnt), 32'(dwn));
        chk("stall", 32'(stall), 32'(ir && !fw));
        chk("m_addr", 32'(m_addr), 32'(e_addr));
        chk("m_rw", 32'(m_rw), 32'(dwn && dwe));
        chk("m_data", 32'(m_data), (dwn && dwe) ? 32'(dw) : 0);
        e_ir = '0;
        e_dr = '0;
        if (pend_if) e_ir = exp_q.pop_front();
        if (pend_d)  e_dr = exp_q.pop_front();
        chk("if_rvalid", 32'(if_rvalid), 32'(pend_if));
        chk("if_rdata", 32'(if_rdata), 32'(e_ir));
        chk("d_rvalid", 32'(d_rvalid), 32'(pend_d));
        chk("d_rdata", 32'(d_rdata), 32'(e_dr));
        starve  = (ir && !fw) ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
        pend_if = fw;
        pend_d  = dwn && !dwe;
        if (fw) exp_q.push_back(ref_mem[ia]);
        if (dwn && !dwe) exp_q.push_back(ref_mem[da]);
        if (dwn && dwe) ref_mem[da] = dw;
        last_fw = fw;
        last_dw = dwn;
        @(posedge clock);
        #1;
    endtask

    logic          cur_ir, cur_dr, cur_dwe;
    logic [AW-1:0] cur_ia, cur_da;
    logic [DW-1:0] cur_dw;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 16'(i * 40503) ^ 16'h5A5A;
            ref_mem[i] = 16'(i * 40503) ^ 16'h5A5A;
        end
        reset   = 1'b1;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        model_clear();

        // Outputs while in reset
        repeat (2) @(posedge clock);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        // Sequential fetch 0..7, one grant per cycle
        for (int i = 0; i < 8; i++) begin
            step(1'b1, AW'(i), 1'b0, 1'b0, '0, '0);
            chk("seq_fetch_gnt", 32'(obs_if_gnt), 1);
        end
        step(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // Vector table: contention, then starvation relief over 8 data cycles
        vecs.push_back('{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 12'h010, 1'b1, 1'b0, 12'h800, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 8; i++) begin
            vecs.push_back('{1'b1, 12'h020, 1'b1, 1'b0, 12'h040, 16'h0,
                             (i == 4), (i != 4), (i != 4), 1'b0, 1'b1});
        end
        vecs.push_back('{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        foreach (vecs[k]) begin
            step(vecs[k].ir, vecs[k].ia, vecs[k].dr, vecs[k].dwe, vecs[k].da, vecs[k].dw);
            chk("vec_if_gnt", 32'(obs_if_gnt), 32'(vecs[k].e_ig));
            chk("vec_d_gnt", 32'(obs_d_gnt), 32'(vecs[k].e_dg));
            chk("vec_stall", 32'(obs_stall), 32'(vecs[k].e_stall));
            chk("vec_m_rw", 32'(obs_m_rw), 32'(vecs[k].e_rw));
            if (vecs[k].sc) begin
                chk("strict_d_gnt", 32'(obs_s_d_gnt), 1);
                chk("strict_if_gnt", 32'(obs_s_if_gnt), 0);
            end
        end

        // Store then load of the same address returns the new word
        step(1'b0, '0, 1'b1, 1'b1, 12'h123, 16'hBEEF);
        chk("st_m_rw", 32'(obs_m_rw), 1);
        step(1'b0, '0, 1'b1, 1'b0, 12'h123, 16'h0);
        chk("ld_m_rw", 32'(obs_m_rw), 0);
        chk("st_no_rvalid", 32'(obs_d_rvalid), 0);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0);
        chk("ld_rvalid", 32'(obs_d_rvalid), 1);
        chk("ld_rdata", 32'(obs_d_rdata), 32'hBEEF);

        // Reset right after a load grant drops the read
        step(1'b0, '0, 1'b1, 1'b0, 12'h200, 16'h0);
        reset   = 1'b1;
        d_req   = 1'b0;
        d_addr  = '0;
        #1;
        chk_zero("rst_mid");
        @(posedge clock);
        #1;
        chk_zero("rst_hold");
        reset = 1'b0;
        model_clear();
        step(1'b1, 12'h005, 1'b0, 1'b0, '0, '0);
        chk("post_rst_no_d_rvalid", 32'(obs_d_rvalid), 0);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // Randomized traffic; each port holds its request until granted
        cur_ir = 1'b0;
        cur_dr = 1'b0;
        cur_dwe = 1'b0;
        cur_ia = '0;
        cur_da = '0;
        cur_dw = '0;
        for (int n = 0; n < 400; n++) begin
            if (!cur_ir || last_fw) begin
                cur_ir = ($urandom_range(0, 3) != 0);
                cur_ia = AW'($urandom_range(0, 31));
            end
            if (!cur_dr || last_dw) begin
                cur_dr  = ($urandom_range(0, 2) != 0);
                cur_dwe = $urandom_range(0, 1) == 1;
                cur_da  = AW'($urandom_range(0, 15));
                cur_dw  = DW'($urandom);
            end
            last_fw = 1'b0;
            last_dw = 1'b0;
            step(cur_ir, cur_ia, cur_dr, cur_dwe, cur_da, cur_dw);
        end
        step(1'b0, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
